// File: rtl/insn_decoder_pkg.sv
// Shared definitions for the decode stage: widths, field positions, opcodes.
package insn_decoder_pkg;

  // Default sizing of the decode stage
  localparam int DEF_LEN_INSN      = 32;
  localparam int DEF_MEM_INSN_ADDR = 10;
  localparam int DEF_N_REG         = 32;
  localparam int DEF_LAT_WB        = 3;

  // Field widths
  localparam int LEN_OPC = 6;
  localparam int LEN_REG = 5;
  localparam int LEN_IMM = 16;
  localparam int LEN_CNT = 3;
  localparam int LAT_WB  = DEF_LAT_WB;

  // Field positions inside the instruction word
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // opcode bit selecting the immediate form
  localparam int OPC_IMM_BIT = LEN_OPC - 1;

  // Opcodes that never write rd
  localparam logic [LEN_OPC-1:0] OPC_NOP = 6'h00;
  localparam logic [LEN_OPC-1:0] OPC_ST  = 6'h01;
  localparam logic [LEN_OPC-1:0] OPC_BR  = 6'h02;

  // Decoded register-side fields of one instruction
  typedef struct packed {
    logic [LEN_OPC-1:0] opcode;
    logic [LEN_REG-1:0] rd;
    logic [LEN_REG-1:0] rs1;
    logic [LEN_REG-1:0] rs2;
    logic               imm_form;
    logic               we;
  } dec_t;

  // An instruction produces a register result unless it targets r0 or is NOP/ST/BR
  function automatic logic writes_rd(input logic [LEN_OPC-1:0] opc,
                                     input logic [LEN_REG-1:0] rd);
    return (rd != '0) && (opc != OPC_NOP) && (opc != OPC_ST) && (opc != OPC_BR);
  endfunction

endpackage

// File: rtl/insn_decoder_scoreboard.sv
// Per-register writeback scoreboard: one small down-counter per architectural
// register, loaded when a writer issues, read through two busy ports.
module insn_scoreboard
  import insn_decoder_pkg::*;
#(
  parameter int N_REG  = DEF_N_REG,
  parameter int LAT_WB = DEF_LAT_WB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_en_i,
  input  logic               ld_en_i,
  input  logic [LEN_REG-1:0] ld_idx_i,
  input  logic [LEN_REG-1:0] rd_a_idx_i,
  input  logic [LEN_REG-1:0] rd_b_idx_i,
  output logic               busy_a_o,
  output logic               busy_b_o
);

  // The counter holds the cycles a reader must still wait. A writer issuing at
  // the end of cycle t has its result readable in cycle t+LAT_WB, so the first
  // cycle a dependent can look (t+1) still has LAT_WB-1 cycles to wait.
  localparam logic [LEN_CNT-1:0] LD_VAL = LEN_CNT'(LAT_WB - 1);

  logic [N_REG-1:0][LEN_CNT-1:0] cnt_q, cnt_d;

  // Next counter values: saturating decrement, load overrides; r0 never tracked
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < N_REG; i++) begin
      if (dec_en_i && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - LEN_CNT'(1);
      if (ld_en_i && (ld_idx_i == LEN_REG'(i))) cnt_d[i] = LD_VAL;
    end
    cnt_d[0] = '0;
  end

  // Counter array register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Busy read ports; out-of-range or r0 indices are never busy
  always_comb begin
    busy_a_o = 1'b0;
    busy_b_o = 1'b0;
    if ((rd_a_idx_i != '0) && (32'(rd_a_idx_i) < N_REG)) busy_a_o = (cnt_q[rd_a_idx_i] != '0);
    if ((rd_b_idx_i != '0) && (32'(rd_b_idx_i) < N_REG)) busy_b_o = (cnt_q[rd_b_idx_i] != '0);
  end

endmodule

// File: rtl/insn_decoder.sv
// Decode stage: registers the fetched word, splits it into fields and holds
// dependent instructions back until their source registers are written back.
module insn_decoder
  import insn_decoder_pkg::*;
#(
  parameter int LEN_INSN      = DEF_LEN_INSN,
  parameter int MEM_INSN_ADDR = DEF_MEM_INSN_ADDR,
  parameter int N_REG         = DEF_N_REG,
  parameter int LAT_WB        = DEF_LAT_WB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  output logic                     stall_o,
  input  logic [LEN_INSN-1:0]      insn_i,
  input  logic [MEM_INSN_ADDR-1:0] addr_i,
  output logic                     valid_o,
  input  logic                     stall_i,
  output logic [LEN_OPC-1:0]       opcode_o,
  output logic [LEN_REG-1:0]       rd_o,
  output logic [LEN_REG-1:0]       rs1_o,
  output logic [LEN_REG-1:0]       rs2_o,
  output logic [LEN_INSN-1:0]      imm_o,
  output logic                     we_o,
  output logic [MEM_INSN_ADDR-1:0] addr_o,
  output logic                     hazard_o
);

  logic                     vld_q, vld_d;
  logic [LEN_INSN-1:0]      insn_q, insn_d;
  logic [MEM_INSN_ADDR-1:0] addr_q, addr_d;
  logic [LEN_IMM-1:0]       imm_raw;
  dec_t                     dec;
  logic                     busy_rs1, busy_rs2;
  logic                     hazard, issue;

  // Capture the fetcher output unless interlocked or backpressured
  always_comb begin
    vld_d  = vld_q;
    insn_d = insn_q;
    addr_d = addr_q;
    if (!stall_o) begin
      vld_d  = valid_i;
      insn_d = insn_i;
      addr_d = addr_i;
    end
  end

  // Pipeline register between fetch and decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      insn_q <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      insn_q <= insn_d;
      addr_q <= addr_d;
    end
  end

  // Field split of the held word; rs2 is meaningless in immediate form
  always_comb begin
    dec          = '0;
    dec.opcode   = insn_q[OPC_MSB:OPC_LSB];
    dec.rd       = insn_q[RD_MSB:RD_LSB];
    dec.rs1      = insn_q[RS1_MSB:RS1_LSB];
    dec.imm_form = dec.opcode[OPC_IMM_BIT];
    dec.rs2      = dec.imm_form ? '0 : insn_q[RS2_MSB:RS2_LSB];
    dec.we       = writes_rd(dec.opcode, dec.rd);
    imm_raw      = insn_q[IMM_MSB:IMM_LSB];
  end

  insn_scoreboard #(
    .N_REG  (N_REG),
    .LAT_WB (LAT_WB)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .dec_en_i   (~stall_i),
    .ld_en_i    (issue & dec.we),
    .ld_idx_i   (dec.rd),
    .rd_a_idx_i (dec.rs1),
    .rd_b_idx_i (dec.rs2),
    .busy_a_o   (busy_rs1),
    .busy_b_o   (busy_rs2)
  );

  // Interlock and handshake: a bubble never stalls the fetcher
  always_comb begin
    hazard  = vld_q & (busy_rs1 | (~dec.imm_form & busy_rs2));
    valid_o = vld_q & ~hazard;
    stall_o = hazard | (vld_q & stall_i);
    issue   = valid_o & ~stall_i;
  end

  // Output fields straight from the held register
  always_comb begin
    opcode_o = dec.opcode;
    rd_o     = dec.rd;
    rs1_o    = dec.rs1;
    rs2_o    = dec.rs2;
    we_o     = dec.we;
    imm_o    = dec.imm_form ? {{(LEN_INSN-LEN_IMM){imm_raw[LEN_IMM-1]}}, imm_raw} : '0;
    addr_o   = addr_q;
    hazard_o = hazard;
  end

endmodule

// File: tb/tb_insn_decoder.sv
// Bench for insn_decoder: decode table, RAW interlock sequences, reset.
module tb_insn_decoder;
  localparam int LI = 32;
  localparam int LA = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i = 1'b0;
  logic          stall_i = 1'b0;
  logic [LI-1:0] insn_i = '0;
  logic [LA-1:0] addr_i = '0;
  logic          stall_o, valid_o, we_o, hazard_o;
  logic [5:0]    opcode_o;
  logic [4:0]    rd_o, rs1_o, rs2_o;
  logic [LI-1:0] imm_o;
  logic [LA-1:0] addr_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  insn_decoder #(.LEN_INSN(LI), .MEM_INSN_ADDR(LA), .N_REG(32), .LAT_WB(3)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o), .insn_i(insn_i),
    .addr_i(addr_i), .valid_o(valid_o), .stall_i(stall_i), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .we_o(we_o),
    .addr_o(addr_o), .hazard_o(hazard_o)
  );

  typedef struct {
    logic [LI-1:0] insn;
    logic [LA-1:0] addr;
    logic [5:0]    opc;
    logic [4:0]    rd, rs1, rs2;
    logic [LI-1:0] imm;
    logic          we;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkr(input logic [5:0] o, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2);
    return {o, d, s1, s2, 11'd0};
  endfunction

  function automatic logic [31:0] mki(input logic [5:0] o, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [15:0] im);
    return {o, d, s1, im};
  endfunction

  // Reference decode used for the hand-written sequences
  function automatic vec_t model(input logic [31:0] ins, input logic [LA-1:0] a);
    vec_t v;
    logic immf;
    v.insn = ins;
    v.addr = a;
    v.opc  = ins[31:26];
    v.rd   = ins[25:21];
    v.rs1  = ins[20:16];
    immf   = ins[31];
    v.rs2  = immf ? 5'd0 : ins[15:11];
    v.imm  = immf ? {{16{ins[15]}}, ins[15:0]} : 32'd0;
    v.we   = (v.rd != 5'd0) && (v.opc != 6'h00) && (v.opc != 6'h01) && (v.opc != 6'h02);
    return v;
  endfunction

  // One clock: drive just after the rising edge, return at the falling edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [LA-1:0] a,
                      input logic si);
    @(posedge clk);
    #1;
    valid_i = v;
    insn_i  = ins;
    addr_i  = a;
    stall_i = si;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, '0, 1'b0);
  endtask

  task automatic send(input logic [31:0] ins, input logic [LA-1:0] a);
    step(1'b1, ins, a, 1'b0);
    exp_q.push_back(model(ins, a));
  endtask

  task automatic obs(input string nm, input logic hz, input logic st, input logic vo);
    chk({nm, "_hazard"}, 32'(hazard_o), 32'(hz));
    chk({nm, "_stall"},  32'(stall_o),  32'(st));
    chk({nm, "_valid"},  32'(valid_o),  32'(vo));
  endtask

  // Scoreboard: every issue is matched against the oldest expected record
  always @(negedge clk) begin
    if (rst && valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL spurious_issue: got issue at addr %h, want none", addr_o);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("iss_addr",   32'(addr_o),   32'(e.addr));
        chk("iss_opcode", 32'(opcode_o), 32'(e.opc));
        chk("iss_rd",     32'(rd_o),     32'(e.rd));
        chk("iss_rs1",    32'(rs1_o),    32'(e.rs1));
        chk("iss_rs2",    32'(rs2_o),    32'(e.rs2));
        chk("iss_imm",    imm_o,         e.imm);
        chk("iss_we",     32'(we_o),     32'(e.we));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mkr(6'h04, 5'd1, 5'd2, 5'd3),     10'h100, 6'h04, 5'd1,  5'd2,  5'd3,  32'h0000_0000, 1'b1};
    tbl[1] = '{mki(6'h24, 5'd6, 5'd7, 16'h8001), 10'h101, 6'h24, 5'd6,  5'd7,  5'd0,  32'hFFFF_8001, 1'b1};
    tbl[2] = '{mki(6'h24, 5'd31, 5'd30, 16'h7FFF), 10'h102, 6'h24, 5'd31, 5'd30, 5'd0, 32'h0000_7FFF, 1'b1};
    tbl[3] = '{mkr(6'h01, 5'd9, 5'd10, 5'd11),   10'h103, 6'h01, 5'd9,  5'd10, 5'd11, 32'h0000_0000, 1'b0};
    tbl[4] = '{mkr(6'h02, 5'd12, 5'd13, 5'd14),  10'h104, 6'h02, 5'd12, 5'd13, 5'd14, 32'h0000_0000, 1'b0};
    tbl[5] = '{32'h0000_0000,                    10'h105, 6'h00, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 1'b0};
    tbl[6] = '{mkr(6'h10, 5'd0, 5'd4, 5'd5),     10'h106, 6'h10, 5'd0,  5'd4,  5'd5,  32'h0000_0000, 1'b0};
    tbl[7] = '{mki(6'h3F, 5'd0, 5'd0, 16'h1234), 10'h107, 6'h3F, 5'd0,  5'd0,  5'd0,  32'h0000_1234, 1'b0};

    // Reset state while the fetcher presents a real instruction
    valid_i = 1'b1;
    insn_i  = mkr(6'h04, 5'd1, 5'd2, 5'd3);
    addr_i  = 10'h3FF;
    repeat (2) @(negedge clk);
    obs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_opcode", 32'(opcode_o), 32'd0);
    chk("reset_imm",    imm_o,         32'd0);
    chk("reset_we",     32'(we_o),     32'd0);
    chk("reset_addr",   32'(addr_o),   32'd0);
    rst     = 1'b1;
    valid_i = 1'b0;

    // Decode table, each entry isolated by idle cycles
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].insn, tbl[i].addr, 1'b0);
      exp_q.push_back(tbl[i]);
      step(1'b0, 32'd0, '0, 1'b0);
      obs("tbl", 1'b0, 1'b0, 1'b1);
      idle(3);
    end

    // Independent stream issues back to back
    send(mkr(6'h04, 5'd1, 5'd2, 5'd3), 10'h010);
    send(mkr(6'h04, 5'd4, 5'd5, 5'd6), 10'h011);
    obs("ind1", 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("ind2", 1'b0, 1'b0, 1'b1);
    idle(3);

    // RAW on rs1: two bubble cycles, issue on the third
    send(mkr(6'h04, 5'd1, 5'd2, 5'd3), 10'h020);
    send(mkr(6'h04, 5'd7, 5'd1, 5'd2), 10'h021);
    obs("raw_w", 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("raw_h1", 1'b1, 1'b1, 1'b0);
    chk("raw_h1_addr", 32'(addr_o), 32'h021);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("raw_h2", 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("raw_iss", 1'b0, 1'b0, 1'b1);
    chk("raw_iss_addr", 32'(addr_o), 32'h021);
    idle(3);

    // RAW on rs2 with downstream stall: counters freeze for 4 cycles
    send(mkr(6'h04, 5'd2, 5'd3, 5'd4), 10'h030);
    send(mkr(6'h04, 5'd8, 5'd9, 5'd2), 10'h031);
    obs("ds_w", 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("ds_h0", 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'd0, '0, 1'b1);
      obs("ds_hold", 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, '0, 1'b0);
    obs("ds_h5", 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("ds_iss", 1'b0, 1'b0, 1'b1);
    // a bubble never stalls the fetcher, even under backpressure
    step(1'b0, 32'd0, '0, 1'b1);
    obs("bubble_stall", 1'b0, 1'b0, 1'b0);
    // backpressure holds a ready instruction in place
    send(mkr(6'h04, 5'd11, 5'd12, 5'd13), 10'h038);
    step(1'b0, 32'd0, '0, 1'b1);
    obs("bp1", 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'd0, '0, 1'b1);
    obs("bp2", 1'b0, 1'b1, 1'b1);
    chk("bp2_addr", 32'(addr_o), 32'h038);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("bp_iss", 1'b0, 1'b0, 1'b1);
    idle(3);

    // r0 is never tracked; immediate form sign-extends and drops rs2
    send(mkr(6'h04, 5'd0, 5'd1, 5'd2), 10'h040);
    send(mki(6'h24, 5'd5, 5'd0, 16'hFFFF), 10'h041);
    obs("r0_a", 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("r0_b", 1'b0, 1'b0, 1'b1);
    chk("r0_imm", imm_o, 32'hFFFF_FFFF);
    chk("r0_rs2", 32'(rs2_o), 32'd0);
    chk("r0_we",  32'(we_o),  32'd1);
    idle(3);

    // Back-to-back writes to r3: the second load restarts the count
    send(mkr(6'h04, 5'd3, 5'd8, 5'd9), 10'h050);
    send(mkr(6'h04, 5'd3, 5'd10, 5'd11), 10'h051);
    obs("rl_w1", 1'b0, 1'b0, 1'b1);
    send(mkr(6'h04, 5'd12, 5'd3, 5'd0), 10'h052);
    obs("rl_w2", 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("rl_h1", 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("rl_h2", 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("rl_iss", 1'b0, 1'b0, 1'b1);
    idle(3);

    // Reset in the middle of a hazard discards the waiting instruction
    send(mkr(6'h04, 5'd10, 5'd1, 5'd2), 10'h060);
    step(1'b1, mkr(6'h04, 5'd13, 5'd10, 5'd0), 10'h061, 1'b0);
    obs("rst_pre_w", 1'b0, 1'b0, 1'b1);
    step(1'b1, mkr(6'h04, 5'd14, 5'd15, 5'd16), 10'h062, 1'b0);
    obs("rst_pre_h", 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    obs("rst_mid", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_addr",   32'(addr_o),   32'd0);
    chk("rst_mid_opcode", 32'(opcode_o), 32'd0);
    @(negedge clk);
    rst     = 1'b1;
    valid_i = 1'b0;
    // counters were cleared, so the former dependent now issues at once
    send(mkr(6'h04, 5'd13, 5'd10, 5'd0), 10'h061);
    step(1'b0, 32'd0, '0, 1'b0);
    obs("rst_post", 1'b0, 1'b0, 1'b1);
    idle(3);

    chk("pending_issues", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
